// File: rtl/field_op_sequencer.sv
// field_op_sequencer: computes (a*b + c - d) mod P by sequencing an external modular multiplier and adder
module field_op_sequencer #(
  parameter int P = 37,
  parameter int WIDTH = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] r,
  output logic             mul_en,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_r,
  input  logic             mul_done,
  output logic             add_en,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_r,
  input  logic             add_done
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] PW = WIDTH'(P);
  typedef enum logic [2:0] {IDLE, S1, GAP, S2, FIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] ab, cmd, neg_d;
  logic bad_d, accept, expired, mul_hit, add_hit;
  assign busy = state == S1 || state == GAP || state == S2;
  assign done = state == FIN;
  assign bad_d = d >= PW;
  assign accept = state == IDLE && start && !bad_d;
  assign neg_d = d == '0 ? '0 : PW - d;
  assign expired = busy && cnt == CW'(TIMEOUT - 1);
  assign mul_hit = mul_en && mul_done;
  assign add_hit = add_en && add_done;
  always_comb begin
    state_n = state;
    if (expired) state_n = IDLE;
    else case (state)
      IDLE:    state_n = accept ? S1 : IDLE;
      S1:      state_n = (!mul_en || mul_done) && (!add_en || add_done) ? GAP : S1;
      GAP:     state_n = !mul_done && !add_done ? S2 : GAP;
      S2:      state_n = add_hit ? FIN : S2;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      err <= 1'b0;
      cnt <= '0;
      mul_en <= 1'b0;
      add_en <= 1'b0;
      r <= '0;
      mul_a <= '0;
      mul_b <= '0;
      add_a <= '0;
      add_b <= '0;
      ab <= '0;
      cmd <= '0;
    end else begin
      state <= state_n;
      err <= expired || (state == IDLE && start && bad_d);
      cnt <= (state_n != state || !busy) ? '0 : cnt + 1'b1;
      if (accept) begin
        mul_en <= 1'b1;
        add_en <= 1'b1;
        mul_a <= a;
        mul_b <= b;
        add_a <= c;
        add_b <= neg_d;
      end
      if (state == S1 && mul_hit) begin
        ab <= mul_r;
        mul_en <= 1'b0;
      end
      if (state == S1 && add_hit) begin
        cmd <= add_r;
        add_en <= 1'b0;
      end
      if (state == GAP && state_n == S2) begin
        add_a <= ab;
        add_b <= cmd;
      end
      if (state == S2 && !add_en && !add_done) add_en <= 1'b1;
      if (state == S2 && add_hit) add_en <= 1'b0;
      if (state_n == FIN) r <= add_r;
      if (expired) begin
        mul_en <= 1'b0;
        add_en <= 1'b0;
      end
    end
  end
endmodule
